// File: rtl/key_control_decoder_pkg.sv
// Scan codes, parser states, axis encodings and key lookup
// shared by the key decoder and its axis resolvers.
package key_control_decoder_pkg;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_P1_UP = 8'h1D;
  localparam logic [7:0] SC_P1_DN = 8'h1B;
  localparam logic [7:0] SC_P1_LF = 8'h1C;
  localparam logic [7:0] SC_P1_RT = 8'h23;
  localparam logic [7:0] SC_P1_BO = 8'h12;
  localparam logic [7:0] SC_P2_BO = 8'h59;
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_P2_UP = 8'h75;
  localparam logic [7:0] SC_P2_DN = 8'h72;
  localparam logic [7:0] SC_P2_LF = 8'h6B;
  localparam logic [7:0] SC_P2_RT = 8'h74;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    AX_NONE = 2'd0,
    AX_NEG  = 2'd1,
    AX_POS  = 2'd2
  } axis_e;

  localparam int NKEYS = 11;

  localparam logic [3:0] K_P1_UP = 4'd0;
  localparam logic [3:0] K_P1_DN = 4'd1;
  localparam logic [3:0] K_P1_LF = 4'd2;
  localparam logic [3:0] K_P1_RT = 4'd3;
  localparam logic [3:0] K_P1_BO = 4'd4;
  localparam logic [3:0] K_P2_UP = 4'd5;
  localparam logic [3:0] K_P2_DN = 4'd6;
  localparam logic [3:0] K_P2_LF = 4'd7;
  localparam logic [3:0] K_P2_RT = 4'd8;
  localparam logic [3:0] K_P2_BO = 4'd9;
  localparam logic [3:0] K_ENTER = 4'd10;

  typedef struct packed {
    logic       hit;
    logic [3:0] idx;
  } key_hit_t;

  function automatic key_hit_t key_lookup(
    input logic       ext,
    input logic [7:0] code
  );
    key_hit_t r;
    r.hit = 1'b1;
    r.idx = K_P1_UP;
    if (!ext) begin
      case (code)
        SC_P1_UP: r.idx = K_P1_UP;
        SC_P1_DN: r.idx = K_P1_DN;
        SC_P1_LF: r.idx = K_P1_LF;
        SC_P1_RT: r.idx = K_P1_RT;
        SC_P1_BO: r.idx = K_P1_BO;
        SC_P2_BO: r.idx = K_P2_BO;
        SC_ENTER: r.idx = K_ENTER;
        default:  r.hit = 1'b0;
      endcase
    end else begin
      case (code)
        SC_P2_UP: r.idx = K_P2_UP;
        SC_P2_DN: r.idx = K_P2_DN;
        SC_P2_LF: r.idx = K_P2_LF;
        SC_P2_RT: r.idx = K_P2_RT;
        default:  r.hit = 1'b0;
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/key_control_decoder_axis_resolve.sv
// Collapses a negative/positive held-key pair into an axis code;
// both or neither held reads as no motion.
module axis_resolve
  import key_control_decoder_pkg::*;
(
  input  logic       i_neg,
  input  logic       i_pos,
  output logic [1:0] o_code
);

  axis_e w_code;

  always_comb begin
    w_code = AX_NONE;
    if (i_neg && !i_pos) w_code = AX_NEG;
    if (i_pos && !i_neg) w_code = AX_POS;
  end

  assign o_code = w_code;

endmodule

// File: rtl/key_control_decoder.sv
// PS/2 set-2 scan byte parser tracking held game keys for two
// players, with prefix timeout and an Enter start pulse.
module key_control_decoder
  import key_control_decoder_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 100_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       byte_valid,
  input  logic [7:0] byte_data,
  input  logic       release_all,
  output logic [1:0] p1_h_code,
  output logic [1:0] p1_v_code,
  output logic [1:0] p2_h_code,
  output logic [1:0] p2_v_code,
  output logic       p1_boost,
  output logic       p2_boost,
  output logic       start_pulse
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TMO = CW'(TIMEOUT_CYCLES);

  state_e           r_state;
  logic [CW-1:0]    r_cnt;
  logic [NKEYS-1:0] r_keys;
  logic             r_start;

  logic     w_prefix;
  logic     w_ext;
  logic     w_brk;
  key_hit_t w_hit;

  assign w_prefix = (byte_data == SC_EXT) || (byte_data == SC_BRK);
  assign w_ext = (r_state == ST_EXT) || (r_state == ST_EXT_BRK);
  assign w_brk = (r_state == ST_BRK) || (r_state == ST_EXT_BRK);
  assign w_hit = key_lookup(w_ext, byte_data);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_keys  <= '0;
      r_start <= 1'b0;
    end else begin
      r_start <= 1'b0;
      if (release_all) begin
        r_state <= ST_IDLE;
        r_cnt   <= '0;
        r_keys  <= '0;
      end else if (byte_valid) begin
        r_cnt <= '0;
        if (w_prefix) begin
          unique case (r_state)
            ST_IDLE:
              r_state <= (byte_data == SC_EXT) ? ST_EXT : ST_BRK;
            ST_EXT:
              r_state <= (byte_data == SC_EXT) ? ST_EXT : ST_EXT_BRK;
            ST_BRK:
              r_state <= (byte_data == SC_EXT) ? ST_IDLE : ST_BRK;
            ST_EXT_BRK:
              r_state <= ST_IDLE;
          endcase
        end else begin
          r_state <= ST_IDLE;
          if (w_hit.hit) begin
            r_keys[w_hit.idx] <= !w_brk;
            if (w_hit.idx == K_ENTER && !w_brk && !r_keys[K_ENTER])
              r_start <= 1'b1;
          end
        end
      end else if (r_state != ST_IDLE) begin
        // Abandon a stale prefix so a later byte parses fresh
        if (r_cnt == TMO) begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  axis_resolve u_p1_h (
    .i_neg  (r_keys[K_P1_LF]),
    .i_pos  (r_keys[K_P1_RT]),
    .o_code (p1_h_code)
  );

  axis_resolve u_p1_v (
    .i_neg  (r_keys[K_P1_UP]),
    .i_pos  (r_keys[K_P1_DN]),
    .o_code (p1_v_code)
  );

  axis_resolve u_p2_h (
    .i_neg  (r_keys[K_P2_LF]),
    .i_pos  (r_keys[K_P2_RT]),
    .o_code (p2_h_code)
  );

  axis_resolve u_p2_v (
    .i_neg  (r_keys[K_P2_UP]),
    .i_pos  (r_keys[K_P2_DN]),
    .o_code (p2_v_code)
  );

  assign p1_boost    = r_keys[K_P1_BO];
  assign p2_boost    = r_keys[K_P2_BO];
  assign start_pulse = r_start;

endmodule

// File: tb/tb_key_control_decoder.sv
// Directed-vector bench for the key control decoder.
module tb_key_control_decoder;

  localparam int TMO = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       byte_valid = 1'b0;
  logic [7:0] byte_data = 8'h00;
  logic       release_all = 1'b0;
  logic [1:0] p1_h_code;
  logic [1:0] p1_v_code;
  logic [1:0] p2_h_code;
  logic [1:0] p2_v_code;
  logic       p1_boost;
  logic       p2_boost;
  logic       start_pulse;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  key_control_decoder #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk         (clk),
    .rst         (rst),
    .byte_valid  (byte_valid),
    .byte_data   (byte_data),
    .release_all (release_all),
    .p1_h_code   (p1_h_code),
    .p1_v_code   (p1_v_code),
    .p2_h_code   (p2_h_code),
    .p2_v_code   (p2_v_code),
    .p1_boost    (p1_boost),
    .p2_boost    (p2_boost),
    .start_pulse (start_pulse)
  );

  // {p1_h, p1_v, p2_h, p2_v, p1_boost, p2_boost, start}
  function automatic logic [10:0] outs();
    return {p1_h_code, p1_v_code, p2_h_code, p2_v_code,
            p1_boost, p2_boost, start_pulse};
  endfunction

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    byte_valid = 1'b1;
    byte_data  = b;
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    byte_valid = 1'b1;
    byte_data = 8'h1C;
    release_all = 1'b1;
    idle(2);
    byte_valid = 1'b0;
    release_all = 1'b0;
    rst = 1'b0;
    total++;
    if (outs() !== 11'h000) begin
      bad++;
      $display("FAIL reset_outs got=%h want=000", outs());
    end
  endtask

  task automatic test_p1_left();
    send(8'h1C);
    total++;
    if (p1_h_code !== 2'd1) begin
      bad++;
      $display("FAIL left_make got=%0d want=1", p1_h_code);
    end
    send(8'h1C);
    total++;
    if (p1_h_code !== 2'd1) begin
      bad++;
      $display("FAIL left_typematic got=%0d want=1", p1_h_code);
    end
    send(8'hF0);
    total++;
    if (p1_h_code !== 2'd1) begin
      bad++;
      $display("FAIL left_after_f0 got=%0d want=1", p1_h_code);
    end
    send(8'h1C);
    total++;
    if (p1_h_code !== 2'd0) begin
      bad++;
      $display("FAIL left_break got=%0d want=0", p1_h_code);
    end
  endtask

  task automatic test_extended();
    send(8'hE0);
    send(8'h75);
    total++;
    if (outs() !== 11'b00_00_00_01_0_0_0) begin
      bad++;
      $display("FAIL ext_p2_up got=%b want=%b", outs(), 11'b00000001000);
    end
    send(8'h1D);
    total++;
    if (p2_v_code !== 2'd1 || p1_v_code !== 2'd1) begin
      bad++;
      $display("FAIL both_up got=%0d/%0d want=1/1", p1_v_code, p2_v_code);
    end
    send(8'hE0);
    send(8'hF0);
    send(8'h75);
    total++;
    if (p2_v_code !== 2'd0 || p1_v_code !== 2'd1) begin
      bad++;
      $display("FAIL ext_break got=%0d/%0d want=1/0", p1_v_code, p2_v_code);
    end
    send(8'hF0);
    send(8'h1D);
    send(8'hE0);
    send(8'h72);
    total++;
    if (outs() !== 11'b00_00_00_10_0_0_0) begin
      bad++;
      $display("FAIL ext_p2_down got=%b want=%b", outs(), 11'b00000010000);
    end
    send(8'hE0);
    send(8'hF0);
    send(8'h72);
  endtask

  task automatic test_both_held();
    send(8'h1C);
    send(8'h23);
    total++;
    if (p1_h_code !== 2'd0) begin
      bad++;
      $display("FAIL lr_both got=%0d want=0", p1_h_code);
    end
    send(8'hF0);
    send(8'h1C);
    total++;
    if (p1_h_code !== 2'd2) begin
      bad++;
      $display("FAIL right_only got=%0d want=2", p1_h_code);
    end
    send(8'hF0);
    send(8'h23);
    total++;
    if (outs() !== 11'h000) begin
      bad++;
      $display("FAIL lr_clear got=%h want=000", outs());
    end
  endtask

  task automatic test_start();
    int pulses;
    pulses = 0;
    send(8'h5A);
    total++;
    if (start_pulse !== 1'b1) begin
      bad++;
      $display("FAIL start_first got=%b want=1", start_pulse);
    end
    idle(1);
    total++;
    if (start_pulse !== 1'b0) begin
      bad++;
      $display("FAIL start_width got=%b want=0", start_pulse);
    end
    for (int i = 0; i < 2; i++) begin
      send(8'h5A);
      if (start_pulse) pulses++;
    end
    total++;
    if (pulses != 0) begin
      bad++;
      $display("FAIL start_typematic got=%0d want=0", pulses);
    end
    send(8'hF0);
    send(8'h5A);
    total++;
    if (start_pulse !== 1'b0) begin
      bad++;
      $display("FAIL start_on_break got=%b want=0", start_pulse);
    end
    send(8'h5A);
    total++;
    if (start_pulse !== 1'b1) begin
      bad++;
      $display("FAIL start_second got=%b want=1", start_pulse);
    end
    idle(1);
    total++;
    if (start_pulse !== 1'b0) begin
      bad++;
      $display("FAIL start_second_width got=%b want=0", start_pulse);
    end
    send(8'hF0);
    send(8'h5A);
  endtask

  task automatic test_timeout();
    send(8'hE0);
    idle(5);
    send(8'h6B);
    total++;
    if (p2_h_code !== 2'd1) begin
      bad++;
      $display("FAIL ext_before_tmo got=%0d want=1", p2_h_code);
    end
    send(8'hE0);
    send(8'hF0);
    send(8'h6B);
    total++;
    if (p2_h_code !== 2'd0) begin
      bad++;
      $display("FAIL ext_clear got=%0d want=0", p2_h_code);
    end
    send(8'hE0);
    idle(TMO + 5);
    send(8'h6B);
    total++;
    if (outs() !== 11'h000) begin
      bad++;
      $display("FAIL tmo_drop got=%h want=000", outs());
    end
    send(8'hE0);
    send(8'h12);
    total++;
    if (p1_boost !== 1'b0) begin
      bad++;
      $display("FAIL ext_12 got=%b want=0", p1_boost);
    end
    send(8'hE0);
    send(8'h5A);
    total++;
    if (start_pulse !== 1'b0) begin
      bad++;
      $display("FAIL ext_5a got=%b want=0", start_pulse);
    end
  endtask

  task automatic test_unmapped();
    send(8'hE1);
    send(8'h14);
    send(8'h77);
    send(8'hE1);
    send(8'hF0);
    send(8'h14);
    send(8'hF0);
    send(8'h77);
    total++;
    if (outs() !== 11'h000) begin
      bad++;
      $display("FAIL unmapped got=%h want=000", outs());
    end
    send(8'h1D);
    send(8'hF0);
    send(8'hE0);
    send(8'h1D);
    total++;
    if (p1_v_code !== 2'd1) begin
      bad++;
      $display("FAIL malformed_drop got=%0d want=1", p1_v_code);
    end
    send(8'hF0);
    send(8'h1D);
  endtask

  task automatic test_release();
    send(8'h12);
    send(8'h59);
    send(8'h1D);
    total++;
    if (outs() !== 11'b00_01_00_00_1_1_0) begin
      bad++;
      $display("FAIL held3 got=%b want=%b", outs(), 11'b00010000110);
    end
    @(negedge clk);
    release_all = 1'b1;
    byte_valid = 1'b1;
    byte_data = 8'h23;
    @(negedge clk);
    release_all = 1'b0;
    byte_valid = 1'b0;
    total++;
    if (outs() !== 11'h000) begin
      bad++;
      $display("FAIL release_all got=%h want=000", outs());
    end
    idle(2);
    total++;
    if (p1_h_code !== 2'd0) begin
      bad++;
      $display("FAIL release_drop got=%0d want=0", p1_h_code);
    end
  endtask

  task automatic test_reset_mid();
    send(8'hF0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    send(8'h1C);
    total++;
    if (p1_h_code !== 2'd1) begin
      bad++;
      $display("FAIL reset_mid got=%0d want=1", p1_h_code);
    end
    @(negedge clk);
    rst = 1'b1;
    byte_valid = 1'b1;
    byte_data = 8'h23;
    @(negedge clk);
    rst = 1'b0;
    byte_valid = 1'b0;
    total++;
    if (outs() !== 11'h000) begin
      bad++;
      $display("FAIL reset_over_byte got=%h want=000", outs());
    end
  endtask

  initial begin
    test_reset();
    test_p1_left();
    test_extended();
    test_both_held();
    test_start();
    test_timeout();
    test_unmapped();
    test_release();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
